// File: rtl/r_ptr_empty.sv
// r_ptr_empty: async FIFO read-side pointer, Gray export, registered empty/almost-empty/count, read strobe, sticky underflow
//   r_clk, r_rst           clock, synchronous active-high reset
//   r_inc, r_uf_clr        read request (honoured only when not empty), underflow clear
//   ff2_w_ptr              Gray write pointer already synchronised into r_clk
//   r_ptr, r_addr          Gray read pointer, RAM read address
//   r_empty, r_almost_empty, r_count, r_valid, r_underflow  registered status
module r_ptr_empty #(
  parameter int ADDR_BITS = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_inc,
  input  logic                 r_uf_clr,
  input  logic [ADDR_BITS:0]   ff2_w_ptr,
  output logic [ADDR_BITS:0]   r_ptr,
  output logic [ADDR_BITS-1:0] r_addr,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic [ADDR_BITS:0]   r_count,
  output logic                 r_valid,
  output logic                 r_underflow
);
  localparam logic [ADDR_BITS:0] AE = AE_THRESH[ADDR_BITS:0];
  logic [ADDR_BITS:0] r_bin_q, r_bin_d, r_ptr_q, r_ptr_d, r_count_q, r_count_d, w_bin_s;
  logic r_empty_q, r_empty_d, r_ae_q, r_ae_d, r_valid_q, r_valid_d, r_uf_q, r_uf_d, rd;
  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i <= ADDR_BITS; i++) begin : g_dec
    assign w_bin_s[i] = ^ff2_w_ptr[ADDR_BITS:i];
  end
  // flags use next-state pointer so they line up with the r_ptr being exported
  always_comb begin
    rd        = r_inc & ~r_empty_q;
    r_bin_d   = r_bin_q + {{ADDR_BITS{1'b0}}, rd};
    r_ptr_d   = (r_bin_d >> 1) ^ r_bin_d;
    r_count_d = w_bin_s - r_bin_d;
    r_empty_d = r_ptr_d == ff2_w_ptr;
    r_ae_d    = r_count_d <= AE;
    r_valid_d = rd;
    r_uf_d    = (r_inc & r_empty_q) | (r_uf_q & ~r_uf_clr);
  end
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_bin_q   <= '0;
      r_ptr_q   <= '0;
      r_count_q <= '0;
      r_empty_q <= 1'b1;
      r_ae_q    <= 1'b1;
      r_valid_q <= 1'b0;
      r_uf_q    <= 1'b0;
    end else begin
      r_bin_q   <= r_bin_d;
      r_ptr_q   <= r_ptr_d;
      r_count_q <= r_count_d;
      r_empty_q <= r_empty_d;
      r_ae_q    <= r_ae_d;
      r_valid_q <= r_valid_d;
      r_uf_q    <= r_uf_d;
    end
  end
  assign r_ptr          = r_ptr_q;
  assign r_addr         = r_bin_q[ADDR_BITS-1:0];
  assign r_empty        = r_empty_q;
  assign r_almost_empty = r_ae_q;
  assign r_count        = r_count_q;
  assign r_valid        = r_valid_q;
  assign r_underflow    = r_uf_q;
endmodule
